// File: rtl/phase_sequencer.sv
// Four-phase lights sequencer feeding the millisecond delay stage; each phase is a pattern plus a dwell.
// All outputs registered (one edge from decision to output); waits on go in RUN, abort returns to idle next edge.
`timescale 1ns/1ps
module phase_sequencer #(
  parameter int                 LIGHT_W = 3,
  parameter logic [11:0]        T0      = 12'd500,
  parameter logic [11:0]        T1      = 12'd100,
  parameter logic [11:0]        T2      = 12'd500,
  parameter logic [11:0]        T3      = 12'd0,
  parameter logic [LIGHT_W-1:0] P0      = 3'b100,
  parameter logic [LIGHT_W-1:0] P1      = 3'b010,
  parameter logic [LIGHT_W-1:0] P2      = 3'b001,
  parameter logic [LIGHT_W-1:0] P3      = 3'b000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               loop,
  input  logic               go,
  output logic               enable,
  output logic [11:0]        cycles,
  output logic [LIGHT_W-1:0] lights,
  output logic [1:0]         phase,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t               state, state_nxt;
  logic [1:0]           load_k;
  logic                 enable_nxt, busy_nxt, done_nxt;
  logic [11:0]          cycles_nxt;
  logic [LIGHT_W-1:0]   lights_nxt;
  logic [1:0]           phase_nxt;

  logic [3:0] live, above;
  logic       first_ok, next_ok;
  logic [1:0] first_k, next_k;

  // Returns {found, index} of the lowest set bit.
  function automatic logic [2:0] lowest(input logic [3:0] m);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  function automatic logic [11:0] dwell(input logic [1:0] k);
    case (k)
      2'd0:    return T0;
      2'd1:    return T1;
      2'd2:    return T2;
      default: return T3;
    endcase
  endfunction

  function automatic logic [LIGHT_W-1:0] pattern(input logic [1:0] k);
    case (k)
      2'd0:    return P0;
      2'd1:    return P1;
      2'd2:    return P2;
      default: return P3;
    endcase
  endfunction

  // Zero-dwell phases are removed from every search so they are never entered.
  assign live  = {T3 != 12'd0, T2 != 12'd0, T1 != 12'd0, T0 != 12'd0};
  assign above = live & (4'b1110 << phase);
  assign {first_ok, first_k} = lowest(live);
  assign {next_ok, next_k}   = lowest(above);

  always_comb begin
    state_nxt  = state;
    load_k     = first_k;
    enable_nxt = 1'b0;
    cycles_nxt = '0;
    lights_nxt = '0;
    phase_nxt  = '0;
    busy_nxt   = 1'b0;
    done_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (start && !abort) state_nxt = first_ok ? LOAD : DONE;
      end
      LOAD: begin
        // go may still be high from the previous phase, so it is not looked at here.
        state_nxt = abort ? IDLE : RUN;
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (go) begin
          if (next_ok) begin
            state_nxt = LOAD;
            load_k    = next_k;
          end else if (loop) begin
            state_nxt = LOAD;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    case (state_nxt)
      LOAD: begin
        cycles_nxt = dwell(load_k);
        lights_nxt = pattern(load_k);
        phase_nxt  = load_k;
        busy_nxt   = 1'b1;
      end
      RUN: begin
        enable_nxt = 1'b1;
        cycles_nxt = cycles;
        lights_nxt = lights;
        phase_nxt  = phase;
        busy_nxt   = 1'b1;
      end
      DONE:    done_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      enable <= 1'b0;
      cycles <= '0;
      lights <= '0;
      phase  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      enable <= enable_nxt;
      cycles <= cycles_nxt;
      lights <= lights_nxt;
      phase  <= phase_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer with a behavioural delay stage closing the go loop.
`timescale 1ns/1ps
module tb_phase_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, abort, loop;
  logic        frc_en, frc_go, st_go, go;
  logic [11:0] st_cnt;
  logic        enable, busy, done;
  logic [11:0] cycles;
  logic [2:0]  lights;
  logic [1:0]  phase;
  logic [19:0] outv;

  logic        start_z, abort_z, loop_z, go_z;
  logic        en_z, busy_z, done_z;
  logic [11:0] cyc_z;
  logic [2:0]  lights_z;
  logic [1:0]  phase_z;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  phase_sequencer #(.LIGHT_W(3), .T0(12'd5), .T1(12'd2), .T2(12'd3), .T3(12'd0)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .loop(loop), .go(go),
    .enable(enable), .cycles(cycles), .lights(lights), .phase(phase), .busy(busy), .done(done));

  phase_sequencer #(.LIGHT_W(3), .T0(12'd0), .T1(12'd0), .T2(12'd0), .T3(12'd0)) dut_z (
    .clk(clk), .reset(reset), .start(start_z), .abort(abort_z), .loop(loop_z), .go(go_z),
    .enable(en_z), .cycles(cyc_z), .lights(lights_z), .phase(phase_z), .busy(busy_z), .done(done_z));

  assign outv = {enable, cycles, lights, phase, busy, done};
  assign go   = frc_en ? frc_go : st_go;

  // Delay stage: reload while enable is low, count down while high, go once the count is spent.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      st_cnt <= '0;
      st_go  <= 1'b0;
    end else if (!enable) begin
      st_cnt <= cycles;
      st_go  <= 1'b0;
    end else if (st_cnt == 12'd0) begin
      st_go  <= 1'b1;
    end else begin
      st_cnt <= st_cnt - 12'd1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- table vectors (go forced) ----------------
  typedef struct {
    logic        st, ab, lp, g;
    logic [19:0] exp;
    logic [19:0] msk;
  } vec_t;

  function automatic vec_t mk(input logic st, ab, lp, g, en, input logic [11:0] cy,
                              input logic [2:0] li, input logic [1:0] ph, input logic bu, dn);
    vec_t v;
    v.st = st; v.ab = ab; v.lp = lp; v.g = g;
    v.exp = {en, cy, li, ph, bu, dn};
    v.msk = dn ? 20'h80073 : 20'hFFFFF;   // cycles/phase are left open while done pulses
    return v;
  endfunction

  // ---------------- reference model (time based) ----------------
  int          mt[4] = '{5, 2, 3, 0};
  logic [2:0]  mp[4] = '{3'b100, 3'b010, 3'b001, 3'b000};
  int          m_k, m_age;
  bit          m_done;

  function automatic int next_live(input int k);
    for (int j = k + 1; j < 4; j++) if (mt[j] != 0) return j;
    return -1;
  endfunction

  // A phase occupies T+3 cycles: one load plus T+2 counting cycles.
  task automatic model_step(input logic st, input logic ab, input logic lp);
    int nk;
    if (m_done) begin
      m_done = 0;
    end else if (m_k >= 0) begin
      if (ab) m_k = -1;
      else begin
        m_age++;
        if (m_age == mt[m_k] + 3) begin
          nk = next_live(m_k);
          if (nk < 0 && lp) nk = next_live(-1);
          if (nk >= 0) begin m_k = nk; m_age = 0; end
          else begin m_k = -1; m_done = 1; end
        end
      end
    end else if (st && !ab) begin
      nk = next_live(-1);
      if (nk >= 0) begin m_k = nk; m_age = 0; end
      else m_done = 1;
    end
  endtask

  task automatic model_expect(output logic [19:0] e, output logic [19:0] m);
    m = 20'hFFFFF;
    if (m_done) begin
      e = 20'h00001; m = 20'h80073;
    end else if (m_k >= 0) begin
      e = {(m_age >= 1), 12'(mt[m_k]), mp[m_k], 2'(m_k), 1'b1, 1'b0};
    end else begin
      e = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  initial begin
    vec_t        tbl[$];
    logic [2:0]  seg_l[$];
    int          seg_n[$];
    logic [2:0]  exp_l[3];
    int          exp_n[3];
    logic [2:0]  cur;
    logic [19:0] e, m;
    int          cnt, stage, lowrun, last_ph;
    bit          fin, seen;

    reset = 1'b1; start = 1'b0; abort = 1'b0; loop = 1'b0;
    frc_en = 1'b1; frc_go = 1'b0;
    start_z = 1'b0; abort_z = 1'b0; loop_z = 1'b0; go_z = 1'b0;
    exp_l[0] = 3'b100; exp_l[1] = 3'b010; exp_l[2] = 3'b001;
    exp_n[0] = 8; exp_n[1] = 5; exp_n[2] = 6;

    //               st ab lp g   en cyc    lights  ph bu dn
    tbl.push_back(mk(1, 0, 0, 1,  0, 12'd5, 3'b100, 0, 1, 0));  // go ignored in idle/load
    tbl.push_back(mk(0, 0, 0, 1,  1, 12'd5, 3'b100, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0,  1, 12'd5, 3'b100, 0, 1, 0));  // start ignored in run
    tbl.push_back(mk(0, 0, 0, 1,  0, 12'd2, 3'b010, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1,  1, 12'd2, 3'b010, 1, 1, 0));
    tbl.push_back(mk(0, 1, 1, 1,  0, 12'd0, 3'b000, 0, 0, 0));  // abort beats go and loop
    tbl.push_back(mk(1, 1, 0, 0,  0, 12'd0, 3'b000, 0, 0, 0));  // abort beats start
    tbl.push_back(mk(1, 0, 0, 0,  0, 12'd5, 3'b100, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,  1, 12'd5, 3'b100, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1,  0, 12'd2, 3'b010, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,  1, 12'd2, 3'b010, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1,  0, 12'd3, 3'b001, 2, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,  1, 12'd3, 3'b001, 2, 1, 0));
    tbl.push_back(mk(0, 0, 1, 1,  0, 12'd5, 3'b100, 0, 1, 0));  // loop skips zero phase 3
    tbl.push_back(mk(0, 0, 0, 0,  1, 12'd5, 3'b100, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1,  0, 12'd2, 3'b010, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,  1, 12'd2, 3'b010, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1,  0, 12'd3, 3'b001, 2, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,  1, 12'd3, 3'b001, 2, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1,  0, 12'd0, 3'b000, 0, 0, 1));  // done pulse
    tbl.push_back(mk(0, 0, 0, 0,  0, 12'd0, 3'b000, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,  0, 12'd5, 3'b100, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0,  0, 12'd0, 3'b000, 0, 0, 0));  // abort in load
    tbl.push_back(mk(0, 0, 0, 0,  0, 12'd0, 3'b000, 0, 0, 0));

    tick(); tick();
    check("reset_state", outv, 20'h0);
    check("reset_state_z", {en_z, cyc_z, lights_z, phase_z, busy_z, done_z}, 20'h0);
    reset = 1'b0;

    // All dwells zero: done one cycle after start, never busy or enabled.
    start_z = 1'b1; tick(); start_z = 1'b0;
    check("zero_done", {done_z, busy_z, en_z, lights_z}, 6'b100000);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (busy_z || en_z || done_z) seen = 1;
    end
    check("zero_quiet_after", seen, 0);

    foreach (tbl[i]) begin
      start = tbl[i].st; abort = tbl[i].ab; loop = tbl[i].lp; frc_go = tbl[i].g;
      tick();
      check($sformatf("vec%0d", i), outv & tbl[i].msk, tbl[i].exp & tbl[i].msk);
    end
    start = 1'b0; abort = 1'b0; loop = 1'b0; frc_go = 1'b0; frc_en = 1'b0;
    tick();

    // Closed loop, no repeat: lights run lengths.
    pulse_start();
    cur = lights; cnt = 1; fin = 0;
    for (int i = 0; i < 100 && !fin; i++) begin
      tick();
      if (done) fin = 1;
      else if (lights == cur) cnt++;
      else begin seg_l.push_back(cur); seg_n.push_back(cnt); cur = lights; cnt = 1; end
    end
    seg_l.push_back(cur); seg_n.push_back(cnt);
    check("seqA_done_seen", fin, 1);
    check("seqA_segments", seg_l.size(), 3);
    for (int i = 0; i < 3 && i < seg_l.size(); i++) begin
      check($sformatf("seqA_pattern%0d", i), seg_l[i], exp_l[i]);
      check($sformatf("seqA_length%0d", i), seg_n[i], exp_n[i]);
    end
    check("seqA_done_outputs", {done, busy, lights, enable}, 6'b100000);
    tick();
    check("seqA_done_width", done, 0);

    // Closed loop with repeat, then loop cleared during phase 1.
    loop = 1'b1;
    pulse_start();
    stage = 0; lowrun = 0; last_ph = 0; fin = 0;
    for (int i = 0; i < 200 && !fin; i++) begin
      if (busy && !enable) lowrun++;
      else if (busy && enable) begin
        if (lowrun > 0) check("seqB_enable_gap", lowrun, 1);
        lowrun = 0;
      end
      if (stage == 0 && busy && phase == 2'd2) stage = 1;
      else if (stage == 1 && busy && phase != 2'd2) begin
        check("seqB_wrap", {phase, lights, cycles, enable}, {2'd0, 3'b100, 12'd5, 1'b0});
        stage = 2;
      end else if (stage == 2 && phase == 2'd1) begin
        loop = 1'b0; stage = 3;
      end
      if (busy) last_ph = phase;
      if (done) begin
        check("seqB_last_phase", last_ph, 2);
        check("seqB_stage", stage, 3);
        fin = 1;
      end
      if (!fin) tick();
    end
    check("seqB_finished", fin, 1);
    tick();

    // Abort in the same cycle the delay raises go during phase 1.
    pulse_start();
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (phase == 2'd1 && enable && st_go) seen = 1;
      else tick();
    end
    check("seqC_go_seen", seen, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    check("seqC_abort", {lights, enable, busy, done}, 6'b0);
    tick();
    check("seqC_no_done", done, 0);

    // Asynchronous reset in the middle of phase 1.
    pulse_start();
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (phase == 2'd1 && enable) seen = 1;
      else tick();
    end
    check("seqD_run1_seen", seen, 1);
    #3 reset = 1'b1;
    #1 check("seqD_async_reset", outv, 20'h0);
    tick(); reset = 1'b0;
    pulse_start();
    check("seqD_restart", outv, {1'b0, 12'd5, 3'b100, 2'd0, 1'b1, 1'b0});

    // Random start/abort/loop against the time-based model.
    reset = 1'b1; tick(); reset = 1'b0;
    m_k = -1; m_age = 0; m_done = 0;
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom % 8) == 0;
      abort = ($urandom % 60) == 0;
      loop  = ($urandom % 4) != 0;
      model_step(start, abort, loop);
      tick();
      model_expect(e, m);
      check($sformatf("rand%0d", i), outv & m, e & m);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
